key_stepper: RTL

- Sits directly downstream of the 9-bit key/character select stage, consuming its 1-bit strobe and 8-bit ASCII character.
- Accepts a selected key press and decodes the letter to an index 0..25.
- Advances the three-rotor position register with Enigma double-stepping, then presents the letter index plus post-step rotor positions to the substitution path.

---
 rtl/key_stepper.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/key_stepper.sv
// Key decode and three-rotor Enigma stepping stage (IDLE -> STEP -> EMIT).
// Optional key_count output is enabled by defining KEY_STEPPER_COUNT_EN.
module key_stepper #(
    parameter int unsigned NOTCH_R = 16,
    parameter int unsigned NOTCH_M = 4,
    parameter int unsigned NOTCH_L = 21
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_char,
    output logic        in_ready,
    input  logic        load,
    input  logic [14:0] load_pos,
    output logic        out_valid,
    output logic [4:0]  out_idx,
    output logic [4:0]  pos_l,
    output logic [4:0]  pos_m,
    output logic [4:0]  pos_r,
    output logic        bad_char
`ifdef KEY_STEPPER_COUNT_EN
    ,
    output logic [15:0] key_count
`endif
);

    localparam logic [4:0] NR = 5'(NOTCH_R);
    localparam logic [4:0] NM = 5'(NOTCH_M);

    // No fourth rotor exists, so the left notch only needs to be a legal position.
    if (NOTCH_R > 25 || NOTCH_M > 25 || NOTCH_L > 25) begin : g_bad_notch
        $error("key_stepper: notch positions must be 0..25");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] pos_l_q, pos_l_d;
    logic [4:0] pos_m_q, pos_m_d;
    logic [4:0] pos_r_q, pos_r_d;
    logic [4:0] idx_q, idx_d;
    logic [4:0] out_idx_q, out_idx_d;
    logic       out_valid_q, out_valid_d;
    logic       bad_char_q, bad_char_d;
    logic       alive_q, alive_d;
`ifdef KEY_STEPPER_COUNT_EN
    logic [15:0] count_q, count_d;
`endif

    logic       is_upper;
    logic       is_lower;
    logic       is_letter;
    logic [7:0] base_char;
    logic [4:0] dec_idx;

    function automatic logic [4:0] wrap_inc(input logic [4:0] p);
        return (p >= 5'd25) ? 5'd0 : p + 5'd1;
    endfunction

    function automatic logic [4:0] clamp_pos(input logic [4:0] p);
        return (p > 5'd25) ? 5'd0 : p;
    endfunction

    always_comb begin
        is_upper  = (in_char >= 8'h41) && (in_char <= 8'h5A);
        is_lower  = (in_char >= 8'h61) && (in_char <= 8'h7A);
        is_letter = is_upper || is_lower;
        base_char = is_upper ? 8'h41 : 8'h61;
        dec_idx   = 5'(in_char - base_char);
    end

    always_comb begin
        state_d     = state_q;
        pos_l_d     = pos_l_q;
        pos_m_d     = pos_m_q;
        pos_r_d     = pos_r_q;
        idx_d       = idx_q;
        out_idx_d   = out_idx_q;
        out_valid_d = 1'b0;
        bad_char_d  = 1'b0;
        alive_d     = 1'b1;
        in_ready    = 1'b0;
`ifdef KEY_STEPPER_COUNT_EN
        count_d     = count_q;
`endif

        case (state_q)
            IDLE: begin
                // alive_q holds off acceptance for the first edge after reset release.
                in_ready = alive_q && !load;
                if (alive_q && load) begin
                    pos_l_d = clamp_pos(load_pos[14:10]);
                    pos_m_d = clamp_pos(load_pos[9:5]);
                    pos_r_d = clamp_pos(load_pos[4:0]);
`ifdef KEY_STEPPER_COUNT_EN
                    count_d = '0;
`endif
                end else if (alive_q && in_valid) begin
                    if (is_letter) begin
                        idx_d   = dec_idx;
                        state_d = STEP;
                    end else begin
                        bad_char_d = 1'b1;
                    end
                end
            end
            STEP: begin
                // All notch tests use pre-step positions, giving the middle-rotor double step.
                pos_r_d = wrap_inc(pos_r_q);
                if (pos_r_q == NR || pos_m_q == NM) begin
                    pos_m_d = wrap_inc(pos_m_q);
                end
                if (pos_m_q == NM) begin
                    pos_l_d = wrap_inc(pos_l_q);
                end
                state_d = EMIT;
            end
            EMIT: begin
                out_valid_d = 1'b1;
                out_idx_d   = idx_q;
`ifdef KEY_STEPPER_COUNT_EN
                if (count_q != '1) begin
                    count_d = count_q + 16'd1;
                end
`endif
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pos_l_q     <= '0;
            pos_m_q     <= '0;
            pos_r_q     <= '0;
            idx_q       <= '0;
            out_idx_q   <= '0;
            out_valid_q <= 1'b0;
            bad_char_q  <= 1'b0;
            alive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos_l_q     <= pos_l_d;
            pos_m_q     <= pos_m_d;
            pos_r_q     <= pos_r_d;
            idx_q       <= idx_d;
            out_idx_q   <= out_idx_d;
            out_valid_q <= out_valid_d;
            bad_char_q  <= bad_char_d;
            alive_q     <= alive_d;
        end
    end

`ifdef KEY_STEPPER_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign key_count = count_q;
`endif

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign pos_l     = pos_l_q;
    assign pos_m     = pos_m_q;
    assign pos_r     = pos_r_q;
    assign bad_char  = bad_char_q;

endmodule
